// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the sequential multiplier and divider:
// controller states, default format widths and field helpers.
package fp_pkg;

  localparam int FP_EXP_W  = 8;
  localparam int FP_MANT_W = 23;
  localparam int FP_W      = 1 + FP_EXP_W + FP_MANT_W;
  localparam int FP_BIAS   = (2 ** (FP_EXP_W - 1)) - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } fp_state_e;

  function automatic int fp_bias(input int exp_w);
    return (2 ** (exp_w - 1)) - 1;
  endfunction

  function automatic logic fp_sign(input logic [FP_W-1:0] v);
    return v[FP_W-1];
  endfunction

  function automatic logic [FP_EXP_W-1:0] fp_exp(input logic [FP_W-1:0] v);
    return v[FP_W-2 -: FP_EXP_W];
  endfunction

  function automatic logic [FP_MANT_W-1:0] fp_mant(input logic [FP_W-1:0] v);
    return v[FP_MANT_W-1:0];
  endfunction

  function automatic logic [FP_W-1:0] fp_pack(input logic s,
                                              input logic [FP_EXP_W-1:0] e,
                                              input logic [FP_MANT_W-1:0] m);
    return {s, e, m};
  endfunction

endpackage

// File: rtl/fp_mant_shift_add.sv
// Iterative mantissa multiplier: one multiplier bit per cycle, LSB first,
// accumulating the left-shifted multiplicand. Exposes the upper product bits.
module fp_mant_shift_add
  import fp_pkg::*;
#(
  parameter int MANT_WIDTH = FP_MANT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [MANT_WIDTH:0]   i_mcand,
  input  logic [MANT_WIDTH:0]   i_mplier,
  output logic                  o_busy,
  output logic                  o_last,
  output logic [MANT_WIDTH+1:0] o_product_hi
);

  localparam int PW = 2 * MANT_WIDTH + 2;
  localparam int CW = $clog2(MANT_WIDTH + 1);

  logic [PW-1:0]       r_mcand;
  logic [MANT_WIDTH:0] r_mplier;
  logic [PW-1:0]       r_acc;
  logic [CW-1:0]       r_cnt;
  logic                r_busy;

  // Shift-add iteration; the counter runs MANT_WIDTH down to 0 (MANT_WIDTH+1 steps)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= {PW{1'b0}};
      r_mplier <= {(MANT_WIDTH+1){1'b0}};
      r_acc    <= {PW{1'b0}};
      r_cnt    <= {CW{1'b0}};
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= {{(PW-MANT_WIDTH-1){1'b0}}, i_mcand};
      r_mplier <= i_mplier;
      r_acc    <= {PW{1'b0}};
      r_cnt    <= CW'(MANT_WIDTH);
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end else begin
        r_acc <= r_acc;
      end
      r_mcand  <= {r_mcand[PW-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[MANT_WIDTH:1]};
      if (r_cnt == {CW{1'b0}}) begin
        r_busy <= 1'b0;
        r_cnt  <= r_cnt;
      end else begin
        r_busy <= 1'b1;
        r_cnt  <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      r_busy <= 1'b0;
    end
  end

  assign o_busy       = r_busy;
  assign o_last       = r_busy & (r_cnt == {CW{1'b0}});
  assign o_product_hi = r_acc[PW-1:MANT_WIDTH];

endmodule

// File: rtl/fp_seq_multiplier.sv
// Sequential floating-point multiplier: exponent add/unbias, iterative mantissa
// product, one-bit normalization, truncation and overflow/underflow flagging.
module fp_seq_multiplier
  import fp_pkg::*;
#(
  parameter int EXP_WIDTH  = FP_EXP_W,
  parameter int MANT_WIDTH = FP_MANT_W
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          start_in,
  input  logic [EXP_WIDTH+MANT_WIDTH:0] a_in,
  input  logic [EXP_WIDTH+MANT_WIDTH:0] b_in,
  output logic                          ready_out,
  output logic                          done_out,
  output logic [EXP_WIDTH+MANT_WIDTH:0] result_out,
  output logic                          overflow_out,
  output logic                          underflow_out
);

  localparam int XW = EXP_WIDTH + 2;
  localparam logic signed [XW-1:0] BIAS_S    = XW'(fp_bias(EXP_WIDTH));
  localparam logic signed [XW-1:0] EXP_MAX_S = XW'((2 ** EXP_WIDTH) - 1);
  localparam logic signed [XW-1:0] ZERO_S    = {XW{1'b0}};
  localparam logic signed [XW-1:0] ONE_S     = {{(XW-1){1'b0}}, 1'b1};

  fp_state_e              r_state;
  logic                   r_sign;
  logic signed [XW-1:0]   r_exp;

  logic                   w_a_sign;
  logic                   w_b_sign;
  logic [EXP_WIDTH-1:0]   w_a_exp;
  logic [EXP_WIDTH-1:0]   w_b_exp;
  logic [MANT_WIDTH-1:0]  w_a_mant;
  logic [MANT_WIDTH-1:0]  w_b_mant;
  logic                   w_zero;
  logic                   w_mul_start;
  logic signed [XW-1:0]   w_exp_sum;
  logic                   w_mul_busy;
  logic                   w_mul_last;
  logic [MANT_WIDTH+1:0]  w_prod_hi;
  logic signed [XW-1:0]   w_exp_norm;
  logic [MANT_WIDTH-1:0]  w_mant_norm;
  logic [EXP_WIDTH+MANT_WIDTH:0] w_res;
  logic                   w_ovf;
  logic                   w_unf;

  assign w_a_sign = a_in[EXP_WIDTH+MANT_WIDTH];
  assign w_b_sign = b_in[EXP_WIDTH+MANT_WIDTH];
  assign w_a_exp  = a_in[EXP_WIDTH+MANT_WIDTH-1:MANT_WIDTH];
  assign w_b_exp  = b_in[EXP_WIDTH+MANT_WIDTH-1:MANT_WIDTH];
  assign w_a_mant = a_in[MANT_WIDTH-1:0];
  assign w_b_mant = b_in[MANT_WIDTH-1:0];

  // Denormal (zero exponent field) operands are flushed to zero
  assign w_zero      = (w_a_exp == {EXP_WIDTH{1'b0}}) | (w_b_exp == {EXP_WIDTH{1'b0}});
  assign w_mul_start = (r_state == IDLE) & start_in & ~w_zero;
  assign w_exp_sum   = $signed({2'b00, w_a_exp}) + $signed({2'b00, w_b_exp}) - BIAS_S;

  fp_mant_shift_add #(
    .MANT_WIDTH(MANT_WIDTH)
  ) u_mant (
    .clk         (clk_in),
    .rst_n       (rst_n_in),
    .i_start     (w_mul_start),
    .i_mcand     ({1'b1, w_a_mant}),
    .i_mplier    ({1'b1, w_b_mant}),
    .o_busy      (w_mul_busy),
    .o_last      (w_mul_last),
    .o_product_hi(w_prod_hi)
  );

  // Normalize the 2.x product to 1.x, truncating the discarded bits
  always_comb begin
    w_exp_norm  = r_exp;
    w_mant_norm = w_prod_hi[MANT_WIDTH-1:0];
    if (w_prod_hi[MANT_WIDTH+1]) begin
      w_exp_norm  = r_exp + ONE_S;
      w_mant_norm = w_prod_hi[MANT_WIDTH:1];
    end else begin
      w_exp_norm  = r_exp;
      w_mant_norm = w_prod_hi[MANT_WIDTH-1:0];
    end
  end

  // Range check and packing of the normalized result
  always_comb begin
    w_res = {(EXP_WIDTH+MANT_WIDTH+1){1'b0}};
    w_ovf = 1'b0;
    w_unf = 1'b0;
    if (w_exp_norm >= EXP_MAX_S) begin
      w_res = {r_sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
      w_ovf = 1'b1;
    end else if (w_exp_norm <= ZERO_S) begin
      w_res = {r_sign, {(EXP_WIDTH+MANT_WIDTH){1'b0}}};
      w_unf = 1'b1;
    end else begin
      w_res = {r_sign, w_exp_norm[EXP_WIDTH-1:0], w_mant_norm};
    end
  end

  // Controller FSM with registered handshake and result outputs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state       <= IDLE;
      r_sign        <= 1'b0;
      r_exp         <= ZERO_S;
      ready_out     <= 1'b1;
      done_out      <= 1'b0;
      result_out    <= {(EXP_WIDTH+MANT_WIDTH+1){1'b0}};
      overflow_out  <= 1'b0;
      underflow_out <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done_out <= 1'b0;
          if (start_in) begin
            r_sign    <= w_a_sign ^ w_b_sign;
            r_exp     <= w_exp_sum;
            ready_out <= 1'b0;
            if (w_zero) begin
              result_out    <= {w_a_sign ^ w_b_sign, {(EXP_WIDTH+MANT_WIDTH){1'b0}}};
              overflow_out  <= 1'b0;
              underflow_out <= 1'b0;
              done_out      <= 1'b1;
              r_state       <= DONE;
            end else begin
              r_state <= MULT;
            end
          end else begin
            ready_out <= 1'b1;
          end
        end
        MULT: begin
          // The mantissa unit must be running here; if not, recover to IDLE
          if (!w_mul_busy) begin
            r_state   <= IDLE;
            ready_out <= 1'b1;
          end else if (w_mul_last) begin
            r_state <= NORM;
          end else begin
            r_state <= MULT;
          end
        end
        NORM: begin
          result_out    <= w_res;
          overflow_out  <= w_ovf;
          underflow_out <= w_unf;
          done_out      <= 1'b1;
          r_state       <= DONE;
        end
        DONE: begin
          done_out  <= 1'b0;
          ready_out <= 1'b1;
          r_state   <= IDLE;
        end
        default: begin
          done_out  <= 1'b0;
          ready_out <= 1'b1;
          r_state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_seq_multiplier.sv
// Scoreboard bench for fp_seq_multiplier: expectations are queued at accept and
// compared when done_out pulses; latency and handshake are checked inline.
module tb_fp_seq_multiplier;

  localparam int LAT_NORMAL = 25;  // done visible right after edge MANT_WIDTH+2
  localparam int PERIOD_OPS = 27;  // MANT_WIDTH+4

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
  } exp_t;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        start_in;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        ready_out;
  logic        done_out;
  logic [31:0] result_out;
  logic        overflow_out;
  logic        underflow_out;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_done   = 0;
  int   cyc      = 0;

  always #5 clk_in = ~clk_in;

  fp_seq_multiplier dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .start_in     (start_in),
    .a_in         (a_in),
    .b_in         (b_in),
    .ready_out    (ready_out),
    .done_out     (done_out),
    .result_out   (result_out),
    .overflow_out (overflow_out),
    .underflow_out(underflow_out)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t fp_model(input logic [31:0] a, input logic [31:0] b);
    exp_t        r;
    logic        s;
    int          e;
    logic [47:0] p;
    logic [22:0] m;
    s     = a[31] ^ b[31];
    r.ovf = 1'b0;
    r.unf = 1'b0;
    r.res = {s, 31'd0};
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return r;
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    if (p[47]) begin
      m = p[46:24];
      e++;
    end else begin
      m = p[45:23];
    end
    if (e >= 255) begin
      r.res = {s, 8'hFF, 23'd0};
      r.ovf = 1'b1;
    end else if (e <= 0) begin
      r.res = {s, 31'd0};
      r.unf = 1'b1;
    end else begin
      r.res = {s, e[7:0], m};
    end
    return r;
  endfunction

  always @(posedge clk_in) cyc <= cyc + 1;

  // Output monitor: pop and compare on every done pulse
  always @(posedge clk_in) begin
    #1;
    if (done_out === 1'b1) begin
      n_done++;
      if (sb_q.size() == 0) begin
        check_eq("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("result", 64'(result_out), 64'(mon_e.res));
        check_eq("overflow", 64'(overflow_out), 64'(mon_e.ovf));
        check_eq("underflow", 64'(underflow_out), 64'(mon_e.unf));
      end
    end
  end

  task automatic wait_ready(input string tag);
    int guard = 0;
    while (ready_out !== 1'b1 && guard < 100) begin
      @(posedge clk_in); #1;
      guard++;
    end
    if (guard >= 100) check_eq({tag, "_ready_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int lat = 0;
    while (done_out !== 1'b1 && lat < 60) begin
      @(posedge clk_in); #1;
      lat++;
    end
    check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input exp_t e, input int exp_lat);
    wait_ready(tag);
    @(negedge clk_in);
    a_in     = a;
    b_in     = b;
    start_in = 1'b1;
    sb_q.push_back(e);
    @(posedge clk_in); #1;
    start_in = 1'b0;
    a_in     = ~a;
    b_in     = ~b;
    check_eq({tag, "_ready_drop"}, 64'(ready_out), 64'd0);
    wait_done(tag, exp_lat);
  endtask

  initial begin
    int   acc1;
    int   done_before;
    logic [31:0] ra;
    logic [31:0] rb;
    exp_t e;

    rst_n_in = 1'b0;
    start_in = 1'b0;
    a_in     = 32'd0;
    b_in     = 32'd0;
    #12;
    check_eq("rst_ready", 64'(ready_out), 64'd1);
    check_eq("rst_done", 64'(done_out), 64'd0);
    check_eq("rst_result", 64'(result_out), 64'd0);
    check_eq("rst_ovf", 64'(overflow_out), 64'd0);
    check_eq("rst_unf", 64'(underflow_out), 64'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    run_op("mul_2x3",   32'h40000000, 32'h40400000, {32'h40C00000, 1'b0, 1'b0}, LAT_NORMAL);
    run_op("mul_15x15", 32'h3FC00000, 32'h3FC00000, {32'h40100000, 1'b0, 1'b0}, LAT_NORMAL);
    run_op("mul_neg",   32'hC0000000, 32'h40400000, {32'hC0C00000, 1'b0, 1'b0}, LAT_NORMAL);
    run_op("ovf",       32'h7F000000, 32'h40000000, {32'h7F800000, 1'b1, 1'b0}, LAT_NORMAL);
    run_op("unf",       32'h00800000, 32'h3F000000, {32'h00000000, 1'b0, 1'b1}, LAT_NORMAL);
    run_op("zero",      32'h00000000, 32'h40400000, {32'h00000000, 1'b0, 1'b0}, 0);
    run_op("neg_zero",  32'h80000000, 32'h3F800000, {32'h80000000, 1'b0, 1'b0}, 0);

    // start held high with new operands while busy
    wait_ready("ign");
    @(negedge clk_in);
    a_in     = 32'h40000000;
    b_in     = 32'h40400000;
    start_in = 1'b1;
    sb_q.push_back({32'h40C00000, 1'b0, 1'b0});
    @(posedge clk_in); #1;
    acc1 = cyc;
    a_in = 32'h3FC00000;
    b_in = 32'h3FC00000;
    check_eq("ign_ready_drop", 64'(ready_out), 64'd0);
    wait_done("ign_first", LAT_NORMAL);
    sb_q.push_back({32'h40100000, 1'b0, 1'b0});
    wait_ready("ign_second");
    @(posedge clk_in); #1;
    start_in = 1'b0;
    check_eq("ign_accept2", 64'(ready_out), 64'd0);
    check_eq("ign_period", 64'(cyc - acc1), 64'(PERIOD_OPS));
    wait_done("ign_second", LAT_NORMAL);

    // reset mid-operation
    wait_ready("rst_mid");
    @(negedge clk_in);
    a_in     = 32'h40000000;
    b_in     = 32'h40400000;
    start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    repeat (9) @(posedge clk_in);
    #3;
    rst_n_in = 1'b0;
    #1;
    check_eq("rst_mid_ready", 64'(ready_out), 64'd1);
    check_eq("rst_mid_done", 64'(done_out), 64'd0);
    check_eq("rst_mid_result", 64'(result_out), 64'd0);
    check_eq("rst_mid_flags", 64'({overflow_out, underflow_out}), 64'd0);
    done_before = n_done;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (40) @(posedge clk_in);
    #2;
    check_eq("rst_mid_no_done", 64'(n_done), 64'(done_before));
    check_eq("rst_mid_result_held", 64'(result_out), 64'd0);

    for (int i = 0; i < 8; i++) begin
      ra = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 23'($urandom)};
      rb = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 23'($urandom)};
      if (i == 0) ra[30:23] = 8'hFF;
      e = fp_model(ra, rb);
      run_op("rand", ra, rb, e,
             (ra[30:23] == 8'd0 || rb[30:23] == 8'd0) ? 0 : LAT_NORMAL);
    end

    repeat (5) @(posedge clk_in);
    #2;
    check_eq("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
